// File: rtl/display_timing_pkg.sv
// Shared VGA timing constants, scan-position types and the sync/visible decoder.
package display_timing_pkg;

    localparam int unsigned CNT_W       = 10;
    localparam int unsigned FRAME_CNT_W = 8;

    localparam int unsigned H_TOTAL     = 800;
    localparam int unsigned H_SYNC      = 96;
    localparam int unsigned H_VIS_START = 144;
    localparam int unsigned H_VIS_END   = 783;
    localparam int unsigned V_TOTAL     = 525;
    localparam int unsigned V_SYNC      = 2;
    localparam int unsigned V_VIS_START = 35;
    localparam int unsigned V_VIS_END   = 514;

    // Raster geometry; sync lengths count from position 0, visible bounds are inclusive.
    typedef struct packed {
        logic [CNT_W-1:0] hTotal;
        logic [CNT_W-1:0] hSyncLen;
        logic [CNT_W-1:0] hVisStart;
        logic [CNT_W-1:0] hVisEnd;
        logic [CNT_W-1:0] vTotal;
        logic [CNT_W-1:0] vSyncLen;
        logic [CNT_W-1:0] vVisStart;
        logic [CNT_W-1:0] vVisEnd;
    } geometry_t;

    localparam geometry_t VGA_GEOM = '{
        hTotal:    CNT_W'(H_TOTAL),
        hSyncLen:  CNT_W'(H_SYNC),
        hVisStart: CNT_W'(H_VIS_START),
        hVisEnd:   CNT_W'(H_VIS_END),
        vTotal:    CNT_W'(V_TOTAL),
        vSyncLen:  CNT_W'(V_SYNC),
        vVisStart: CNT_W'(V_VIS_START),
        vVisEnd:   CNT_W'(V_VIS_END)
    };

    typedef struct packed {
        logic [CNT_W-1:0] hCount;
        logic [CNT_W-1:0] vCount;
    } scanPos_t;

    typedef struct packed {
        logic hSync;
        logic vSync;
        logic bright;
    } syncBits_t;

    // Active-low syncs and the visible-window flag for a given scan position.
    function automatic syncBits_t decodeScan(input scanPos_t pos, input geometry_t g);
        syncBits_t s;
        s.hSync  = (pos.hCount >= g.hSyncLen);
        s.vSync  = (pos.vCount >= g.vSyncLen);
        s.bright = (pos.hCount >= g.hVisStart) && (pos.hCount <= g.hVisEnd) &&
                   (pos.vCount >= g.vVisStart) && (pos.vCount <= g.vVisEnd);
        return s;
    endfunction

endpackage

// File: rtl/display_timing_if.sv
// Video timing bundle: raster position, syncs and timing strobes.
interface display_timing_if;
    import display_timing_pkg::*;

    logic [CNT_W-1:0] hCount;
    logic [CNT_W-1:0] vCount;
    logic             bright;
    logic             hSync;
    logic             vSync;
    logic             pixelEn;
    logic             frameTick;
    logic             gameTick;

    modport master (
        output hCount, vCount, bright, hSync, vSync, pixelEn, frameTick, gameTick
    );

    modport slave (
        input hCount, vCount, bright, hSync, vSync, pixelEn, frameTick, gameTick
    );

endinterface

// File: rtl/pixel_enable_div.sv
// Divides clk down to a one-cycle pixel strobe every CLK_DIV cycles.
module pixel_enable_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic pixelEn
);

    localparam int unsigned       DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] divCount;
    logic [DIV_W-1:0] divNext;

    // Divider advances every clk and wraps after CLK_DIV-1.
    always_comb begin
        divNext = divCount + DIV_W'(1);
        if (divCount == DIV_LAST) begin
            divNext = '0;
        end
    end

    // pixelEn is registered so it is high exactly while the divider holds its last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            divCount <= '0;
            pixelEn  <= 1'b0;
        end else begin
            divCount <= divNext;
            pixelEn  <= (divNext == DIV_LAST);
        end
    end

endmodule

// File: rtl/display_timing.sv
// VGA raster timing generator: pixel/line counters, syncs, visible window, frame and game ticks.
module display_timing
    import display_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV         = 4,
    parameter int unsigned FRAMES_PER_TICK = 2,
    parameter geometry_t   GEOM            = VGA_GEOM
) (
    input  logic             clk,
    input  logic             rst,
    display_timing_if.master vid
);

    localparam logic [FRAME_CNT_W-1:0] FRAME_LAST = FRAME_CNT_W'(FRAMES_PER_TICK - 1);
    localparam logic [CNT_W-1:0]       H_LAST     = GEOM.hTotal - CNT_W'(1);
    localparam logic [CNT_W-1:0]       V_LAST     = GEOM.vTotal - CNT_W'(1);

    logic                   pixelEn;
    scanPos_t               pos;
    scanPos_t               posNext;
    syncBits_t              syncQ;
    syncBits_t              syncNext;
    logic [FRAME_CNT_W-1:0] frameCount;
    logic [FRAME_CNT_W-1:0] frameNext;
    logic                   frameWrap;
    logic                   gameWrap;
    logic                   frameTickQ;
    logic                   gameTickQ;

    pixel_enable_div #(
        .CLK_DIV(CLK_DIV)
    ) uPixelDiv (
        .clk    (clk),
        .rst    (rst),
        .pixelEn(pixelEn)
    );

    // Scan position: one pixel per pixelEn, wrapping at end of line and end of frame.
    always_comb begin
        posNext   = pos;
        frameWrap = 1'b0;
        if (pixelEn) begin
            if (pos.hCount >= H_LAST) begin
                posNext.hCount = '0;
                if (pos.vCount >= V_LAST) begin
                    posNext.vCount = '0;
                    frameWrap      = 1'b1;
                end else begin
                    posNext.vCount = pos.vCount + CNT_W'(1);
                end
            end else begin
                posNext.hCount = pos.hCount + CNT_W'(1);
            end
        end
    end

    // Frame counter: gameTick fires on the frame wrap that completes FRAMES_PER_TICK frames.
    always_comb begin
        frameNext = frameCount;
        gameWrap  = 1'b0;
        if (frameWrap) begin
            if (frameCount == FRAME_LAST) begin
                frameNext = '0;
                gameWrap  = 1'b1;
            end else begin
                frameNext = frameCount + FRAME_CNT_W'(1);
            end
        end
    end

    // Decode from the next position so registered syncs line up with the registered counts.
    always_comb begin
        syncNext = decodeScan(posNext, GEOM);
    end

    // State register; reset lands on position 0 with both syncs asserted.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos        <= '0;
            frameCount <= '0;
            syncQ      <= '0;
            frameTickQ <= 1'b0;
            gameTickQ  <= 1'b0;
        end else begin
            pos        <= posNext;
            frameCount <= frameNext;
            syncQ      <= syncNext;
            frameTickQ <= frameWrap;
            gameTickQ  <= gameWrap;
        end
    end

    assign vid.hCount    = pos.hCount;
    assign vid.vCount    = pos.vCount;
    assign vid.hSync     = syncQ.hSync;
    assign vid.vSync     = syncQ.vSync;
    assign vid.bright    = syncQ.bright;
    assign vid.pixelEn   = pixelEn;
    assign vid.frameTick = frameTickQ;
    assign vid.gameTick  = gameTickQ;

endmodule

// File: tb/tb_display_timing.sv
// Bench for display_timing: full VGA instance for line timing, shrunken rasters for frame/tick timing.
module tb_display_timing;
    import display_timing_pkg::*;

    // Shrunken raster so whole frames fit in a short run: 20x10 total, 12x5 visible at (5..16, 3..7).
    localparam geometry_t SMALL_GEOM = '{
        hTotal: 10'd20, hSyncLen: 10'd3, hVisStart: 10'd5, hVisEnd: 10'd16,
        vTotal: 10'd10, vSyncLen: 10'd2, vVisStart: 10'd3, vVisEnd: 10'd7
    };
    localparam int unsigned A_DIV = 4;
    localparam int unsigned B_DIV = 2;
    localparam int unsigned B_FRAME_CYC = 2 * 20 * 10;

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       br;
        logic       pe;
        logic       ft;
        logic       gt;
    } obs_t;

    typedef struct {
        int unsigned n;
        logic [9:0]  h;
        logic [9:0]  v;
        logic        hs;
        logic        vs;
        logic        br;
        logic        pe;
    } vec_t;

    logic clk;
    logic rstA;
    logic rstB;

    display_timing_if ifA ();
    display_timing_if ifB ();
    display_timing_if ifC ();

    display_timing uA (.clk(clk), .rst(rstA), .vid(ifA));

    display_timing #(.CLK_DIV(B_DIV), .FRAMES_PER_TICK(2), .GEOM(SMALL_GEOM))
        uB (.clk(clk), .rst(rstB), .vid(ifB));

    display_timing #(.CLK_DIV(B_DIV), .FRAMES_PER_TICK(1), .GEOM(SMALL_GEOM))
        uC (.clk(clk), .rst(rstB), .vid(ifC));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    obs_t actA, actB, actC;
    assign actA = {ifA.hCount, ifA.vCount, ifA.hSync, ifA.vSync, ifA.bright, ifA.pixelEn, ifA.frameTick, ifA.gameTick};
    assign actB = {ifB.hCount, ifB.vCount, ifB.hSync, ifB.vSync, ifB.bright, ifB.pixelEn, ifB.frameTick, ifB.gameTick};
    assign actC = {ifC.hCount, ifC.vCount, ifC.hSync, ifC.vSync, ifC.bright, ifC.pixelEn, ifC.frameTick, ifC.gameTick};

    int checks = 0;
    int failures = 0;
    int unsigned nA = 0;
    int unsigned nB = 0;
    obs_t qA[$];
    obs_t qB[$];
    obs_t qC[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Closed-form expectation after n non-reset edges: everything follows from pixels = n / div.
    function automatic obs_t model(input int unsigned n, input int unsigned d,
                                   input int unsigned fpt, input geometry_t g);
        obs_t r;
        int unsigned ht, vt, p, fp, h, v, frame;
        ht = g.hTotal;
        vt = g.vTotal;
        fp = ht * vt;
        p = n / d;
        h = p % ht;
        v = (p / ht) % vt;
        frame = p / fp;
        r.h  = 10'(h);
        r.v  = 10'(v);
        r.hs = (h >= int'(g.hSyncLen));
        r.vs = (v >= int'(g.vSyncLen));
        r.br = (h >= int'(g.hVisStart)) && (h <= int'(g.hVisEnd)) &&
               (v >= int'(g.vVisStart)) && (v <= int'(g.vVisEnd));
        r.pe = ((n % d) == d - 1);
        r.ft = ((n % d) == 0) && (p > 0) && ((p % fp) == 0);
        r.gt = r.ft && ((frame % fpt) == 0);
        return r;
    endfunction

    // Each clock edge is a stimulus event: derive and enqueue what every DUT must show after it.
    always @(posedge clk) begin
        if (rstA) nA = 0; else nA = nA + 1;
        if (rstB) nB = 0; else nB = nB + 1;
        qA.push_back(model(nA, A_DIV, 2, VGA_GEOM));
        qB.push_back(model(nB, B_DIV, 2, SMALL_GEOM));
        qC.push_back(model(nB, B_DIV, 1, SMALL_GEOM));
    end

    // Pop and compare mid-cycle, away from the active edge.
    always @(negedge clk) begin
        obs_t e;
        if (qA.size() > 0) begin e = qA.pop_front(); check("scoreA", actA, e); end
        if (qB.size() > 0) begin e = qB.pop_front(); check("scoreB", actB, e); end
        if (qC.size() > 0) begin e = qC.pop_front(); check("scoreC", actC, e); end
        check("gameEqFrameC", ifC.gameTick, ifC.frameTick);
    end

    // pixelEn periods with hSync low during the first line of the full-size instance.
    int hsLowPeriods = 0;
    always @(negedge clk) begin
        if (!rstA && nA > 0 && nA < 3200 && ifA.pixelEn && !ifA.hSync) hsLowPeriods++;
    end

    task automatic waitB(input int unsigned target, input string name);
        int budget;
        budget = 5000;
        while (nB != target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check(name, nB, target);
    endtask

    // Called at a negedge: one reset edge on the small instances, released at the next negedge.
    task automatic pulseResetB();
        rstB = 1'b1;
        @(negedge clk);
        rstB = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[11];
        int ftT[$];
        int gtT[$];
        int brightCyc;
        int cTicks;
        int seenAt;
        logic seenBright;
        logic [19:0] firstBr, lastBr;

        vecs[0]  = '{0,    10'd0,   10'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1,    10'd0,   10'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{3,    10'd0,   10'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{4,    10'd1,   10'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{383,  10'd95,  10'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{384,  10'd96,  10'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{576,  10'd144, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{3199, 10'd799, 10'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{3200, 10'd0,   10'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{6400, 10'd0,   10'd2, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{6976, 10'd144, 10'd2, 1'b1, 1'b1, 1'b0, 1'b0};

        rstA = 1'b1;
        rstB = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstA = 1'b0;
        rstB = 1'b0;

        // Full-size instance: spot positions through the first lines.
        for (int i = 0; i < 11; i++) begin
            int budget;
            budget = 10000;
            while (nA < vecs[i].n && budget > 0) begin
                @(negedge clk);
                budget--;
            end
            check($sformatf("tableA[%0d].cycle", i), nA, vecs[i].n);
            check($sformatf("tableA[%0d]", i),
                  {ifA.hCount, ifA.vCount, ifA.hSync, ifA.vSync, ifA.bright, ifA.pixelEn},
                  {vecs[i].h, vecs[i].v, vecs[i].hs, vecs[i].vs, vecs[i].br, vecs[i].pe});
        end
        check("hSyncLowPeriods", hsLowPeriods, 96);

        // Four small frames: tick spacing, game ticks on even frames, visible window extent.
        @(negedge clk);
        pulseResetB();
        brightCyc = 0;
        cTicks = 0;
        seenBright = 1'b0;
        firstBr = '0;
        lastBr = '0;
        for (int k = 0; k < 4 * B_FRAME_CYC + 10; k++) begin
            @(negedge clk);
            if (ifB.frameTick) ftT.push_back(int'(nB));
            if (ifB.gameTick) gtT.push_back(int'(nB));
            if (ifC.gameTick) cTicks++;
            if (ifB.bright && nB < B_FRAME_CYC) begin
                brightCyc++;
                if (!seenBright) firstBr = {ifB.hCount, ifB.vCount};
                seenBright = 1'b1;
                lastBr = {ifB.hCount, ifB.vCount};
            end
        end
        check("frameTickCount", ftT.size(), 4);
        for (int k = 0; k < ftT.size() && k < 4; k++)
            check($sformatf("frameTickAt[%0d]", k), ftT[k], B_FRAME_CYC * (k + 1));
        check("gameTickCount", gtT.size(), 2);
        for (int k = 0; k < gtT.size() && k < 2; k++)
            check($sformatf("gameTickAt[%0d]", k), gtT[k], 2 * B_FRAME_CYC * (k + 1));
        check("gameTickCountFpt1", cTicks, 4);
        check("brightCycles", brightCyc, 12 * 5 * B_DIV);
        check("firstBright", firstBr, {10'd5, 10'd3});
        check("lastBright", lastBr, {10'd16, 10'd7});

        // Mid-frame reset: counters clear, no tick, next frame tick one full frame later.
        pulseResetB();
        waitB(219, "waitMidFrame");
        pulseResetB();
        check("midResetState", {ifB.hCount, ifB.vCount, ifB.frameTick, ifB.gameTick}, 22'd0);
        seenAt = -1;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (ifB.frameTick) begin
                seenAt = int'(nB);
                break;
            end
        end
        check("frameTickAfterMidReset", seenAt, B_FRAME_CYC);

        // Reset on the very edge that would commit a frame wrap (and a game tick) wins.
        waitB(2 * B_FRAME_CYC - 1, "waitWrapEdge");
        check("preWrapPos", {ifB.hCount, ifB.vCount, ifB.pixelEn}, {10'd19, 10'd9, 1'b1});
        pulseResetB();
        check("resetBeatsWrap", {ifB.frameTick, ifB.gameTick, ifC.frameTick, ifC.gameTick}, 4'd0);
        check("resetBeatsWrapPos", {ifB.hCount, ifB.vCount}, 20'd0);

        repeat (20) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/display_timing.md
DISPLAY_TIMING -- requirements
Module: display_timing

Interface
REQ-001 Parameter CLK_DIV, default 4, SHALL set the system clocks per pixel; 100 MHz clk gives a 25 MHz pixel rate.
REQ-002 Parameter FRAMES_PER_TICK, default 2, SHALL set the frames per gameTick pulse; legal range 1..255.
REQ-003 Clock and reset SHALL be one clock and a synchronous, active-high reset.
REQ-004 Port clk, input, 1: system clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1: synchronous active-high reset.
REQ-006 Port hCount, output, 10: horizontal pixel counter, range 0..799.
REQ-007 Port vCount, output, 10: vertical line counter, range 0..524.
REQ-008 Port bright, output, 1: high inside the visible 640x480 window.
REQ-009 Port hSync, output, 1: active-low horizontal sync.
REQ-010 Port vSync, output, 1: active-low vertical sync.
REQ-011 Port pixelEn, output, 1: one-clk pulse on every pixel advance.
REQ-012 Port frameTick, output, 1: one-clk pulse at frame wrap.
REQ-013 Port gameTick, output, 1: one-clk pulse every FRAMES_PER_TICK frames; drives the renderer's gameSCEN capture.

Function
REQ-014 A divider counter SHALL count 0..CLK_DIV-1 and wrap.
REQ-015 pixelEn SHALL be high for the single clk cycle in which the divider equals CLK_DIV-1.
REQ-016 On pixelEn, hCount SHALL increment.
REQ-017 On pixelEn with hCount = 799, hCount SHALL wrap to 0 and vCount SHALL increment.
REQ-018 On pixelEn with hCount = 799 and vCount = 524, both counters SHALL wrap to 0.
REQ-019 Without pixelEn, hCount and vCount SHALL hold.
REQ-020 hSync SHALL be 0 iff hCount is 0..95.
REQ-021 vSync SHALL be 0 iff vCount is 0..1.
REQ-022 bright SHALL be 1 iff hCount is 144..783 and vCount is 35..514.
REQ-023 hSync, vSync and bright SHALL be registered, decoded from the next-count values, so each matches the hCount/vCount present in the same cycle with zero skew.
REQ-024 frameTick SHALL pulse for exactly one clk, in the cycle where the (799,524)->(0,0) wrap is committed.
REQ-025 A frame counter, 8 bits, SHALL increment on each frameTick.
REQ-026 When the frame counter equals FRAMES_PER_TICK-1 on a frameTick, gameTick SHALL pulse in that same cycle and the frame counter SHALL clear to 0.
REQ-027 With FRAMES_PER_TICK = 1, gameTick SHALL equal frameTick.
REQ-028 All count comparisons SHALL be unsigned, 10 bits.
REQ-029 No counter SHALL ever leave its legal range.

Reset
REQ-030 With rst high at a clk edge, the divider, hCount, vCount and frame counter SHALL become 0.
REQ-031 With rst high at a clk edge, hSync and vSync SHALL become 0, consistent with count 0.
REQ-032 With rst high at a clk edge, bright, pixelEn, frameTick and gameTick SHALL become 0.
REQ-033 Reset asserted mid-frame SHALL abort the frame with no frameTick or gameTick.
REQ-034 Reset SHALL take priority over every simultaneous event.
REQ-035 The first pixelEn SHALL occur CLK_DIV clk cycles after rst deasserts.

Structure
REQ-036 Timing constants SHALL live in a shared package: H_TOTAL 800, H_SYNC 96, H_VIS_START 144, H_VIS_END 783, V_TOTAL 525, V_SYNC 2, V_VIS_START 35, V_VIS_END 514.
REQ-037 The divider SHALL be a sub-module named pixel_enable_div, taking clk, rst and CLK_DIV and producing pixelEn.

Verification
REQ-038 rst high, then release -> all outputs 0; first pixelEn at cycle 4; hCount = 1 after the first pixelEn.
REQ-039 Run one line -> hSync low for exactly 96 pixelEn periods; hCount 799 -> 0 wrap; vCount 0 -> 1.
REQ-040 Run one frame -> bright high for exactly 640x480 pixels; first bright pixel at (144,35); last at (783,514).
REQ-041 Run 4 frames with FRAMES_PER_TICK = 2 -> frameTick seen 4 times, 1,680,000 clk apart; gameTick on frames 2 and 4 only; each pulse one clk wide.
REQ-042 Assert rst at (400,300) for 1 clk -> counters 0 next cycle; no frameTick; the next frameTick comes 1,680,000 clk after release.
REQ-043 FRAMES_PER_TICK = 1 -> gameTick identical to frameTick on every cycle.
